// File: rtl/ram_loader.sv
// ram_loader: halts the CPU and streams DEPTH = 2**ADDR_W program bytes onto the main bus as MI/RI write pairs.
// Optional macro RAM_LOADER_VERIFY_EN adds a RAM read-back compare (bus_in/ro) after every write.
module ram_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       hold_ack,
  input  logic       bus_tick,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
`ifdef RAM_LOADER_VERIFY_EN
  input  logic [7:0] bus_in,
  output logic       ro,
`endif
  output logic       byte_ready,
  output logic       cpu_hold,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       mi,
  output logic       ri,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_BYTE,
    S_ADDR,
    S_DATA,
    S_FINISH
`ifdef RAM_LOADER_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_byte;
  logic              r_err;

  logic w_start_acc;
  logic w_capture;
  logic w_addr_inc;
  logic w_set_err;
  logic w_last;
  logic w_active;

  assign w_last   = (r_addr == LAST_ADDR);
  assign w_active = (r_state != S_IDLE);

  // abort outranks every transition, including a start sampled in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_capture   = 1'b0;
    w_addr_inc  = 1'b0;
    w_set_err   = 1'b0;
    if (abort) begin
      if (w_active) begin
        w_state_nxt = S_IDLE;
        w_set_err   = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_HOLD;
            w_start_acc = 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_ack) w_state_nxt = S_WAIT_BYTE;
        end
        S_WAIT_BYTE: begin
          if (byte_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus_tick) w_state_nxt = S_DATA;
        end
`ifdef RAM_LOADER_VERIFY_EN
        S_DATA: begin
          if (bus_tick) w_state_nxt = S_VERIFY;
        end
        S_VERIFY: begin
          if (bus_tick) begin
            if (bus_in == r_byte) begin
              w_addr_inc  = 1'b1;
              w_state_nxt = w_last ? S_FINISH : S_WAIT_BYTE;
            end else begin
              w_set_err   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
`else
        S_DATA: begin
          if (bus_tick) begin
            w_addr_inc  = 1'b1;
            w_state_nxt = w_last ? S_FINISH : S_WAIT_BYTE;
          end
        end
`endif
        S_FINISH: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_byte  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc)     r_addr <= '0;
      else if (w_addr_inc) r_addr <= r_addr + ADDR_W'(1);
      if (w_capture) r_byte <= byte_data;
      if (w_start_acc)    r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;
    end
  end

  always_comb begin
    byte_ready = 1'b0;
    bus_out    = '0;
    bus_oe     = 1'b0;
    mi         = 1'b0;
    ri         = 1'b0;
    cpu_rst    = 1'b0;
    done       = 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
    ro         = 1'b0;
`endif
    cpu_hold   = w_active;
    busy       = w_active;
    err        = r_err;
    case (r_state)
      S_WAIT_BYTE: byte_ready = 1'b1;
      S_ADDR: begin
        bus_out = 8'(r_addr);
        bus_oe  = 1'b1;
        mi      = 1'b1;
      end
      S_DATA: begin
        bus_out = r_byte;
        bus_oe  = 1'b1;
        ri      = 1'b1;
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_VERIFY: ro = 1'b1;
`endif
      S_FINISH: begin
        done    = 1'b1;
        cpu_rst = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: accepted bytes push expected MI/RI bus writes, bus strobes pop and compare.
`timescale 1ns/1ps
module tb_ram_loader;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hold_ack = 1'b0;
  logic       bus_tick = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready, cpu_hold, bus_oe, mi, ri, cpu_rst, busy, done, err;
  logic [7:0] bus_out;
  logic       w_ro;
  logic [16:0] w_outs;

`ifdef RAM_LOADER_VERIFY_EN
  logic [7:0] bus_in = 8'h00;
  logic       ro;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;
  bit         bad_en = 1'b0;
  assign w_ro = ro;
`else
  assign w_ro = 1'b0;
`endif

  assign w_outs = {w_ro, byte_ready, cpu_hold, bus_out, bus_oe, mi, ri, cpu_rst, busy, done, err};

  typedef struct packed {
    logic       is_data;
    logic [7:0] val;
  } sb_t;

  sb_t         sb_q[$];
  logic [7:0]  src_q[$];
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned n_done = 0, n_crst = 0, n_strobes = 0, tick_cnt = 0, exp_addr = 0;
  bit          src_en = 1'b0, take = 1'b0, found;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .hold_ack(hold_ack),
    .bus_tick(bus_tick),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
`ifdef RAM_LOADER_VERIFY_EN
    .bus_in(bus_in),
    .ro(ro),
`endif
    .byte_ready(byte_ready),
    .cpu_hold(cpu_hold),
    .bus_out(bus_out),
    .bus_oe(bus_oe),
    .mi(mi),
    .ri(ri),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic sb_check(input logic is_data, input logic [7:0] val);
    sb_t e;
    n_strobes++;
    if (sb_q.size() == 0) begin
      check_eq(is_data ? "ri_unexpected" : "mi_unexpected", {23'b0, is_data, val}, 32'h0000_0200);
      return;
    end
    e = sb_q.pop_front();
    check_eq(is_data ? "ri_write" : "mi_write", {22'b0, bus_oe, is_data, val}, {22'b0, 1'b1, e});
  endtask

  // one clock: inputs change 1ns after the rising edge, outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    if (take) src_q.delete(0);
    take = 1'b0;
    tick_cnt++;
    bus_tick   = (tick_cnt % 4 == 0);
    byte_valid = src_en && (src_q.size() != 0);
    byte_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
`ifdef RAM_LOADER_VERIFY_EN
    bus_in = (bad_en && last_addr == 8'd2) ? 8'hAA : last_data;
`endif
    @(negedge clk);
    if (rst_n) begin
      if (byte_valid && byte_ready) begin
        take = 1'b1;
        sb_q.push_back({1'b0, 8'(exp_addr)});
        sb_q.push_back({1'b1, byte_data});
        exp_addr++;
      end
      if (bus_tick && mi) begin
        sb_check(1'b0, bus_out);
`ifdef RAM_LOADER_VERIFY_EN
        last_addr = bus_out;
`endif
      end
      if (bus_tick && ri) begin
        sb_check(1'b1, bus_out);
`ifdef RAM_LOADER_VERIFY_EN
        last_data = bus_out;
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      if (bus_tick && ro) check_eq("verify_oe_off", 32'(bus_oe), 32'd0);
`endif
      if (done)    n_done++;
      if (cpu_rst) n_crst++;
    end
  endtask

  task automatic begin_load(input logic [7:0] base);
    src_q.delete();
    sb_q.delete();
    for (int unsigned i = 0; i < DEPTH; i++) src_q.push_back(base + 8'(i));
    src_en   = 1'b1;
    exp_addr = 0;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      step();
      seen = done;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic clear_stream();
    src_q.delete();
    sb_q.delete();
    src_en = 1'b0;
    take   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check_eq("reset_outputs", 32'(w_outs), 32'd0);
    rst_n = 1'b1;
    step();

    // full load with flow control: bytes offered in IDLE/HOLD must not be consumed
    for (int unsigned i = 0; i < DEPTH; i++) src_q.push_back(8'h10 + 8'(i));
    src_en = 1'b1;
    step();
    step();
    check_eq("idle_ignores_stream", 32'(src_q.size()) | {31'b0, cpu_hold}, 32'd16);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("hold_rise", {30'b0, cpu_hold, busy}, 32'd3);
    step();
    step();
    check_eq("hold_no_ready", 32'(byte_ready), 32'd0);
    check_eq("hold_no_consume", 32'(src_q.size()), 32'd16);
    hold_ack = 1'b1;
    step();
    hold_ack = 1'b0;
    check_eq("wait_ready", 32'(byte_ready), 32'd1);
    step();
    check_eq("first_byte_taken", 32'(src_q.size()), 32'd15);
    check_eq("addr_phase_mi", {29'b0, mi, ri, bus_oe}, 32'd5);
    wait_done("full_done_seen", 400);
    check_eq("finish_pulse", {29'b0, cpu_rst, cpu_hold, err}, 32'd6);
    step();
    check_eq("after_finish", {29'b0, cpu_hold, done, busy}, 32'd0);
    check_eq("full_done_count", n_done, 32'd1);
    check_eq("full_crst_count", n_crst, 32'd1);
    check_eq("full_strobes", n_strobes, 32'd32);
    check_eq("full_sb_empty", 32'(sb_q.size()), 32'd0);
    clear_stream();

    // abort during DATA at addr 5
    n_done = 0; n_crst = 0; n_strobes = 0;
    hold_ack = 1'b1;
    begin_load(8'h20);
    found = 1'b0;
    for (int unsigned i = 0; i < 200 && !found; i++) begin
      step();
      found = ri && !bus_tick && (bus_out == 8'h25);
    end
    check_eq("reach_data_addr5", 32'(found), 32'd1);
    check_eq("abort_pending_ri", 32'(sb_q.size()), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_state", {26'b0, err, cpu_hold, busy, bus_oe, mi, ri}, 32'h20);
    check_eq("abort_no_finish", {30'b0, done, cpu_rst}, 32'd0);
    check_eq("abort_done_count", n_done, 32'd0);
    clear_stream();

    // start and abort together in IDLE: stay idle, err kept
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_idle", {30'b0, busy, err}, 32'd1);

    // restart clears err, begins at addr 0; a start pulse mid-load is ignored
    n_done = 0; n_crst = 0; n_strobes = 0;
    begin_load(8'h30);
    check_eq("err_cleared", {30'b0, err, busy}, 32'd1);
    for (int unsigned i = 0; i < 30; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("restart_done_seen", 400);
    check_eq("restart_err", 32'(err), 32'd0);
    check_eq("restart_done_count", n_done, 32'd1);
    check_eq("restart_strobes", n_strobes, 32'd32);
    check_eq("restart_sb_empty", 32'(sb_q.size()), 32'd0);
    step();
    clear_stream();

    // asynchronous reset in the middle of ADDR
    begin_load(8'h40);
    found = 1'b0;
    for (int unsigned i = 0; i < 60 && !found; i++) begin
      step();
      found = mi && !bus_tick;
    end
    check_eq("reach_addr_phase", 32'(found), 32'd1);
    rst_n = 1'b0;
    #2;
    check_eq("async_reset_outputs", 32'(w_outs), 32'd0);
    step();
    rst_n = 1'b1;
    clear_stream();
    step();
    check_eq("post_reset_idle", {29'b0, cpu_hold, busy, byte_ready}, 32'd0);

`ifdef RAM_LOADER_VERIFY_EN
    // read-back mismatch at addr 2 aborts the load
    n_done = 0;
    bad_en = 1'b1;
    src_q.delete();
    begin_load(8'h53);
    found = 1'b0;
    for (int unsigned i = 0; i < 200 && !found; i++) begin
      step();
      found = err;
    end
    check_eq("verify_err_seen", 32'(found), 32'd1);
    check_eq("verify_err_addr", 32'(last_addr), 32'd2);
    check_eq("verify_err_state", {29'b0, cpu_hold, busy, done}, 32'd0);
    check_eq("verify_err_done_count", n_done, 32'd0);
    check_eq("verify_err_sb", 32'(sb_q.size()), 32'd0);
    bad_en = 1'b0;
    clear_stream();
    begin_load(8'h60);
    wait_done("verify_good_done", 600);
    check_eq("verify_good_err", 32'(err), 32'd0);
    check_eq("verify_good_done_count", n_done, 32'd1);
    step();
    clear_stream();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
